pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_pkg.sv | 15 +
 rtl/mux_21w.sv | 13 +
 rtl/pc_fetch_unit.sv | 111 +++++++++++
 tb/tb_pc_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC / fetch-request stage: FSM encoding and
// default reset PC, increment and alignment.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam int          DEF_INC        = 4;
  localparam int          DEF_ALIGN_BITS = 2;

endpackage

// File: rtl/mux_21w.sv
// Width-parameterized 2:1 selector; select=1 picks in2, select=0 picks in1.
module mux_21w #(
  parameter int W = 1
) (
  output logic [W-1:0] y,
  input  logic         select,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2
);

  assign y = select ? in2 : in1;

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and instruction-fetch request stage with
// branch redirect capture and downstream stall handling.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int              INC        = DEF_INC,
  parameter int              ALIGN_BITS = DEF_ALIGN_BITS,
  parameter int              CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              redirect_pending,
  output logic [1:0]        state
);

  // Handshake: a request completes on a rising edge where req_valid=1 and
  // req_ready=1. While req_valid=1 and not yet accepted, req_addr/req_valid
  // hold; stall and branch_taken never withdraw or alter an open request.

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((1 << ALIGN_BITS) - 1));

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] redir_q;
  logic              pend_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              hs;
  logic              sel;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] mux_y;
  logic [ADDR_W-1:0] next_pc;

  assign hs       = (state_q == REQ) && req_ready;
  assign sel      = pend_q | branch_taken;
  assign seq_pc   = pc_q + ADDR_W'(INC);
  // A live branch on the handshake edge overrides an older captured redirect.
  assign redir_pc = branch_taken ? branch_target : redir_q;

  mux_21w #(.W(ADDR_W)) u_next_pc_mux (
    .y      (mux_y),
    .select (sel),
    .in1    (seq_pc),
    .in2    (redir_pc)
  );

  assign next_pc = mux_y & ALIGN_MASK;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (hs && stall) state_d = STALL;
      STALL:   if (!stall) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & ALIGN_MASK;
      redir_q <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (branch_taken) pc_q <= branch_target & ALIGN_MASK;
        end
        REQ: begin
          if (hs) begin
            pc_q   <= next_pc;
            cnt_q  <= cnt_q + CNT_W'(1);
            pend_q <= 1'b0;
          end else if (branch_taken) begin
            redir_q <= branch_target;
            pend_q  <= 1'b1;
          end
        end
        STALL: begin
          if (branch_taken) begin
            pc_q   <= branch_target & ALIGN_MASK;
            pend_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_valid        = (state_q == REQ);
  assign req_addr         = pc_q;
  assign pc               = pc_q;
  assign fetch_count      = cnt_q;
  assign redirect_pending = pend_q;
  assign state            = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit against a cycle-level
// behavioural model of the fetch stage.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] pc;
  logic [15:0] fetch_count;
  logic        redirect_pending;
  logic [1:0]  state;

  int vectors     = 0;
  int miscompares = 0;

  localparam int PH_IDLE  = 0;
  localparam int PH_REQ   = 1;
  localparam int PH_STALL = 2;

  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_redir;
  logic        m_pend;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .pc               (pc),
    .fetch_count      (fetch_count),
    .redirect_pending (redirect_pending),
    .state            (state)
  );

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of one rising edge, using the inputs held across that edge.
  task automatic model_edge();
    if (rst) begin
      m_phase = PH_IDLE;
      m_pc    = 32'h0;
      m_redir = 32'h0;
      m_pend  = 1'b0;
      m_cnt   = 16'h0;
    end else if (m_phase == PH_IDLE) begin
      if (branch_taken) m_pc = al(branch_target);
      m_phase = PH_REQ;
    end else if (m_phase == PH_REQ) begin
      if (req_ready) begin
        if (branch_taken)  m_pc = al(branch_target);
        else if (m_pend)   m_pc = al(m_redir);
        else               m_pc = al(m_pc + 32'd4);
        m_cnt  = m_cnt + 16'd1;
        m_pend = 1'b0;
        if (stall) m_phase = PH_STALL;
      end else if (branch_taken) begin
        m_redir = branch_target;
        m_pend  = 1'b1;
      end
    end else begin
      if (branch_taken) begin
        m_pc   = al(branch_target);
        m_pend = 1'b0;
      end
      if (!stall) m_phase = PH_REQ;
    end
  endtask

  task automatic check_all();
    chk("req_valid", {31'b0, req_valid}, {31'b0, m_phase == PH_REQ});
    chk("req_addr", req_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("fetch_count", {16'b0, fetch_count}, {16'b0, m_cnt});
    chk("redirect_pending", {31'b0, redirect_pending}, {31'b0, m_pend});
    chk("state", {30'b0, state}, 32'(m_phase));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; req_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; req_ready = 1'b0;

    // Reset state and sequential fetch at full throughput.
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_cnt", {16'b0, fetch_count}, 32'h0);
    chk("rst_pend", {31'b0, redirect_pending}, 32'h0);
    chk("rst_state", {30'b0, state}, 32'h0);
    req_ready = 1'b1;
    tick();
    chk("seq_addr0", req_addr, 32'h0);
    chk("seq_valid0", {31'b0, req_valid}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq_addr", req_addr, 32'(4 * i));
      chk("seq_cnt", {16'b0, fetch_count}, 32'(i));
    end

    // Back-pressure at 0x8 with two redirects; the latest wins.
    do_reset();
    req_ready = 1'b1;
    tick(); tick(); tick();
    chk("bp_addr_start", req_addr, 32'h8);
    req_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h40; tick();
    branch_taken = 1'b0; tick();
    branch_taken = 1'b1; branch_target = 32'h80; tick();
    chk("bp_addr_hold", req_addr, 32'h8);
    chk("bp_pend", {31'b0, redirect_pending}, 32'h1);
    branch_taken = 1'b0; req_ready = 1'b1; tick();
    chk("bp_pc", pc, 32'h80);
    chk("bp_pend_clr", {31'b0, redirect_pending}, 32'h0);

    // Handshake with stall and unaligned branch on the same edge.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h103; tick();
    chk("sb_pc", pc, 32'h100);
    chk("sb_state", {30'b0, state}, 32'h2);
    chk("sb_valid", {31'b0, req_valid}, 32'h0);
    branch_taken = 1'b0; stall = 1'b0; tick();
    chk("sb_release_addr", req_addr, 32'h100);

    // Stall held five cycles, branch to 0x200 in the third.
    stall = 1'b1; tick();
    for (int i = 1; i <= 4; i++) begin
      branch_taken = (i == 2);
      branch_target = 32'h200;
      tick();
      if (i == 2) chk("st_pc_now", pc, 32'h200);
    end
    chk("st_cnt_frozen", {16'b0, fetch_count}, 32'h5);
    branch_taken = 1'b0; stall = 1'b0; tick();
    chk("st_first_req", req_addr, 32'h200);
    chk("st_first_valid", {31'b0, req_valid}, 32'h1);

    // Reset mid-request at 0x20 drops it without counting.
    do_reset();
    tick();
    branch_taken = 1'b1; branch_target = 32'h20; req_ready = 1'b1; tick();
    chk("rr_pc", req_addr, 32'h20);
    branch_taken = 1'b1; branch_target = 32'h300; req_ready = 1'b0; tick();
    rst = 1'b1; tick();
    rst = 1'b0; branch_taken = 1'b0;
    chk("rr_pc0", pc, 32'h0);
    chk("rr_valid", {31'b0, req_valid}, 32'h0);
    chk("rr_cnt", {16'b0, fetch_count}, 32'h0);
    chk("rr_pend", {31'b0, redirect_pending}, 32'h0);

    // Randomized traffic including occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 49) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_target = $urandom;
      req_ready     = $urandom_range(0, 1) == 1;
      tick();
    end

    // PC and counter wrap.
    do_reset();
    req_ready = 1'b1;
    tick();
    for (int i = 0; i < 65534; i++) tick();
    chk("wrap_cnt_pre", {16'b0, fetch_count}, 32'h0000_FFFE);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; tick();
    chk("wrap_pc_top", pc, 32'hFFFF_FFFC);
    chk("wrap_cnt_max", {16'b0, fetch_count}, 32'h0000_FFFF);
    branch_taken = 1'b0; tick();
    chk("wrap_pc_zero", pc, 32'h0);
    chk("wrap_cnt_zero", {16'b0, fetch_count}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
